pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid register (main + skid) between pipeline stages.
// in_ready comes only from registered state, so out_ready has no combinational
// path to the upstream side.
// Optional stall counter: define PIPE_STAGE_PERF_CNT_EN to add the stall_cnt
// port and its saturating counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BUBBLE_ZERO = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Reject illegal widths at elaboration time.
  if (DATA_W < 1 || DATA_W > 256 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_reg: illegal DATA_W=%0d or CNT_W=%0d", DATA_W, CNT_W);
  end

  logic [1:0]        state;
  logic [DATA_W-1:0] main;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] bubble;

  // Value main takes whenever the stage drains to EMPTY.
  always_comb begin
    bubble = main;
    if (BUBBLE_ZERO != 0) bubble = '0;
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main;

  // State and payload registers; flush overrides every other input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
      main  <= bubble;
      skid  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main  <= in_data;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            main <= in_data;
          end else if (!in_valid && out_ready) begin
            main  <= bubble;
            state <= EMPTY;
          end else if (in_valid && !out_ready) begin
            skid  <= in_data;
            state <= FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid plays no part.
          if (out_ready) begin
            main  <= skid;
            state <= BUSY;
          end
        end
        default: begin
          state <= EMPTY;
          main  <= '0;
          skid  <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  // Count stalled edges, saturating at all-ones; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
